boxcar_lpf_stream: RTL and testbench

- Parametrised running-sum moving-average low-pass filter for the signed audio sample path, one sample per `in_valid` strobe.
- Selectable average length N = 2^k, with k = 0..MAX_LOG2; k = 0 is bypass.
- Circular-buffer history plus a single accumulator (add newest, subtract oldest), so area is independent of N.
- Adds over the previous fixed-tap filter: a valid handshake, a clean re-prime on length change, a rounding option and a `settled` status flag.

---
 rtl/lpf_pkg.sv | 18 +
 rtl/boxcar_lpf_stream_if.sv | 24 ++
 rtl/sample_ring_ram.sv | 39 +++
 rtl/boxcar_lpf_stream.sv | 137 +++++++++++++
 tb/tb_boxcar_lpf_stream.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/lpf_pkg.sv
// Shared types and helpers for the boxcar moving-average filter.
package lpf_pkg;

  typedef enum logic [1:0] {
    BYPASS = 2'd0,
    PRIME  = 2'd1,
    RUN    = 2'd2
  } lpf_state_t;

  localparam int ROUND_FLOOR   = 0;
  localparam int ROUND_HALF_UP = 1;

  // Requests longer than the history buffer collapse onto the longest window.
  function automatic int clamp_k(input int sel, input int max_k);
    return (sel > max_k) ? max_k : sel;
  endfunction

endpackage

// File: rtl/boxcar_lpf_stream_if.sv
// Sample stream between a producer and the boxcar filter.
interface boxcar_lpf_stream_if #(
  parameter int BIT_WIDTH = 24,
  parameter int SEL_W     = 3
);

  logic [SEL_W-1:0]            filt_sel;
  logic                        in_valid;
  logic signed [BIT_WIDTH-1:0] d;
  logic                        out_valid;
  logic signed [BIT_WIDTH-1:0] q;
  logic                        settled;

  modport master (
    output filt_sel, in_valid, d,
    input  out_valid, q, settled
  );

  modport slave (
    input  filt_sel, in_valid, d,
    output out_valid, q, settled
  );

endinterface

// File: rtl/sample_ring_ram.sv
// Circular sample history: one write per accepted sample, asynchronous read
// of the sample a given distance behind the write pointer.
module sample_ring_ram #(
  parameter int WIDTH  = 24,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] rd_offset,
  output logic [WIDTH-1:0]  rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wptr;

  // An offset of zero means a full buffer length back, which is the slot about to be overwritten.
  assign rdata = mem[wptr - rd_offset];

  // Storage has no reset; the filter never reads a slot it has not written.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wptr] <= wdata;
    end
  end

  // Write pointer wraps naturally at the buffer depth.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
    end else if (we) begin
      wptr <= wptr + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/boxcar_lpf_stream.sv
// Running-sum moving-average low-pass filter with selectable length 2^k.
// One accumulator adds the newest sample and subtracts the oldest one.
module boxcar_lpf_stream
  import lpf_pkg::*;
#(
  parameter int BIT_WIDTH = 24,
  parameter int MAX_LOG2  = 6,
  parameter int ROUND     = 0,
  parameter int SEL_W     = $clog2(MAX_LOG2 + 1)
) (
  input logic                clk,
  input logic                reset,
  boxcar_lpf_stream_if.slave bus
);

  localparam int ACC_W = BIT_WIDTH + MAX_LOG2;

  lpf_state_t                state;
  logic [SEL_W-1:0]          k_cur;
  logic signed [ACC_W-1:0]   acc;
  logic [MAX_LOG2-1:0]       fill;

  logic [SEL_W-1:0]          k_req;
  logic                      len_change;
  logic [SEL_W-1:0]          k_eff;
  lpf_state_t                st_eff;
  logic signed [ACC_W-1:0]   acc_eff;
  logic [MAX_LOG2-1:0]       fill_eff;
  logic [MAX_LOG2-1:0]       n_m1;
  logic [MAX_LOG2-1:0]       rd_offset;
  logic [BIT_WIDTH-1:0]      oldest;
  logic signed [ACC_W-1:0]   d_ext;
  logic signed [ACC_W-1:0]   old_ext;
  logic signed [ACC_W-1:0]   acc_sum;
  logic signed [ACC_W-1:0]   rnd;
  logic signed [ACC_W-1:0]   rnd_sum;
  logic signed [ACC_W-1:0]   shifted;

  lpf_state_t                state_nxt;
  logic signed [ACC_W-1:0]   acc_nxt;
  logic [MAX_LOG2-1:0]       fill_nxt;
  logic signed [BIT_WIDTH-1:0] q_nxt;
  logic                      settled_nxt;

  sample_ring_ram #(
    .WIDTH  (BIT_WIDTH),
    .ADDR_W (MAX_LOG2)
  ) u_ring (
    .clk       (clk),
    .reset     (reset),
    .we        (bus.in_valid),
    .wdata     (bus.d),
    .rd_offset (rd_offset),
    .rdata     (oldest)
  );

  // Window bookkeeping: a length change restarts the window with this sample as its first.
  always_comb begin
    k_req      = SEL_W'(clamp_k(int'(bus.filt_sel), MAX_LOG2));
    len_change = (k_req != k_cur);
    k_eff      = len_change ? k_req : k_cur;
    st_eff     = len_change ? ((k_req == '0) ? BYPASS : PRIME) : state;
    acc_eff    = len_change ? '0 : acc;
    fill_eff   = len_change ? '0 : fill;
    n_m1       = MAX_LOG2'((32'd1 << k_eff) - 32'd1);
    rd_offset  = n_m1 + MAX_LOG2'(1);
    d_ext      = {{MAX_LOG2{bus.d[BIT_WIDTH-1]}}, bus.d};
    old_ext    = {{MAX_LOG2{oldest[BIT_WIDTH-1]}}, oldest};
  end

  // Accumulator update, scaling with optional half-up rounding, and next-state choice.
  always_comb begin
    state_nxt   = st_eff;
    acc_nxt     = acc_eff;
    fill_nxt    = fill_eff;
    q_nxt       = bus.d;
    settled_nxt = 1'b0;
    acc_sum     = acc_eff + d_ext;
    if (st_eff == RUN) begin
      acc_sum = acc_eff + d_ext - old_ext;
    end
    rnd = '0;
    if (ROUND == ROUND_HALF_UP && k_eff != '0) begin
      rnd = ACC_W'(1) << (k_eff - SEL_W'(1));
    end
    rnd_sum = acc_sum + rnd;
    shifted = rnd_sum >>> k_eff;
    case (st_eff)
      BYPASS: begin
        acc_nxt     = '0;
        q_nxt       = bus.d;
        settled_nxt = 1'b1;
      end
      PRIME: begin
        acc_nxt  = acc_sum;
        fill_nxt = fill_eff + MAX_LOG2'(1);
        if (fill_eff == n_m1) begin
          q_nxt       = shifted[BIT_WIDTH-1:0];
          settled_nxt = 1'b1;
          state_nxt   = RUN;
        end
      end
      RUN: begin
        acc_nxt     = acc_sum;
        q_nxt       = shifted[BIT_WIDTH-1:0];
        settled_nxt = 1'b1;
      end
      default: begin
        state_nxt = PRIME;
      end
    endcase
  end

  // Filter state and registered outputs advance only on accepted samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= PRIME;
      k_cur         <= '0;
      acc           <= '0;
      fill          <= '0;
      bus.q         <= '0;
      bus.out_valid <= 1'b0;
      bus.settled   <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        state       <= state_nxt;
        k_cur       <= k_eff;
        acc         <= acc_nxt;
        fill        <= fill_nxt;
        bus.q       <= q_nxt;
        bus.settled <= settled_nxt;
      end
    end
  end

endmodule

// File: tb/tb_boxcar_lpf_stream.sv
// Directed bench: one floor-mode and one round-mode filter fed identical samples.
module tb_boxcar_lpf_stream;

  localparam int BW   = 24;
  localparam int ML   = 6;
  localparam int SELW = 3;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  boxcar_lpf_stream_if #(.BIT_WIDTH(BW), .SEL_W(SELW)) bus_f ();
  boxcar_lpf_stream_if #(.BIT_WIDTH(BW), .SEL_W(SELW)) bus_r ();

  boxcar_lpf_stream #(.BIT_WIDTH(BW), .MAX_LOG2(ML), .ROUND(0), .SEL_W(SELW)) u_floor (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_f)
  );

  boxcar_lpf_stream #(.BIT_WIDTH(BW), .MAX_LOG2(ML), .ROUND(1), .SEL_W(SELW)) u_round (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_r)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic drive(input int sel, input logic vld, input int dval);
    bus_f.filt_sel = SELW'(sel);
    bus_r.filt_sel = SELW'(sel);
    bus_f.in_valid = vld;
    bus_r.in_valid = vld;
    bus_f.d        = BW'(dval);
    bus_r.d        = BW'(dval);
  endtask

  task automatic apply_stimulus(input string tag, input int sel, input int dval,
                                input int exp_floor, input int exp_round, input int exp_settled);
    @(negedge clk);
    drive(sel, 1'b1, dval);
    @(posedge clk);
    #1;
    drive(sel, 1'b0, dval);
    check_output({tag, ".vld_f"}, int'(bus_f.out_valid), 1);
    check_output({tag, ".vld_r"}, int'(bus_r.out_valid), 1);
    check_output({tag, ".q_f"}, int'(bus_f.q), exp_floor);
    check_output({tag, ".q_r"}, int'(bus_r.q), exp_round);
    check_output({tag, ".set_f"}, int'(bus_f.settled), exp_settled);
    check_output({tag, ".set_r"}, int'(bus_r.settled), exp_settled);
  endtask

  task automatic idle_cycle(input string tag, input int sel);
    @(negedge clk);
    drive(sel, 1'b0, 0);
    @(posedge clk);
    #1;
    check_output({tag, ".vld_f"}, int'(bus_f.out_valid), 0);
    check_output({tag, ".vld_r"}, int'(bus_r.out_valid), 0);
  endtask

  initial begin
    int dv;
    int ef;
    int er;
    int es;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    drive(0, 1'b0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_output("rst.q_f", int'(bus_f.q), 0);
    check_output("rst.q_r", int'(bus_r.q), 0);
    check_output("rst.vld_f", int'(bus_f.out_valid), 0);
    check_output("rst.set_f", int'(bus_f.settled), 0);
    check_output("rst.set_r", int'(bus_r.settled), 0);
    @(negedge clk);
    reset = 1'b0;

    // Bypass
    apply_stimulus("byp0", 0, 100, 100, 100, 1);
    apply_stimulus("byp1", 0, -5, -5, -5, 1);
    apply_stimulus("byp2", 0, 7, 7, 7, 1);
    idle_cycle("byp_idle", 0);

    // Prime and settle at k=2
    apply_stimulus("k2_0", 2, 4, 4, 4, 0);
    apply_stimulus("k2_1", 2, 8, 8, 8, 0);
    apply_stimulus("k2_2", 2, 12, 12, 12, 0);
    apply_stimulus("k2_3", 2, 16, 10, 10, 1);
    apply_stimulus("k2_4", 2, 20, 14, 14, 1);

    // Rounding at k=1
    apply_stimulus("k1p_0", 1, 1, 1, 1, 0);
    apply_stimulus("k1p_1", 1, 2, 1, 2, 1);
    apply_stimulus("k1byp", 0, 0, 0, 0, 1);
    apply_stimulus("k1n_0", 1, -1, -1, -1, 0);
    apply_stimulus("k1n_1", 1, -2, -2, -1, 1);

    // Full-scale alternating samples at k=6, wrapping the history; sel=7 clamps to 6
    for (int i = 0; i < 204; i++) begin
      dv = (i % 2 == 0) ? 8388607 : -8388608;
      if (i < 63) begin
        ef = dv; er = dv; es = 0;
      end else begin
        ef = -1; er = 0; es = 1;
      end
      apply_stimulus((i < 200) ? "ext" : "clamp", (i < 200) ? 6 : 7, dv, ef, er, es);
    end

    // k=3 running, then a gap with a new selection, then re-prime at k=1
    for (int i = 0; i < 7; i++) begin
      apply_stimulus("k3p", 3, 8 * (i + 1), 8 * (i + 1), 8 * (i + 1), 0);
    end
    apply_stimulus("k3s", 3, 64, 36, 36, 1);
    apply_stimulus("k3r", 3, 72, 44, 44, 1);
    for (int i = 0; i < 5; i++) begin
      idle_cycle("gap", 1);
    end
    apply_stimulus("chg0", 1, 10, 10, 10, 0);
    apply_stimulus("chg1", 1, 20, 15, 15, 1);
    apply_stimulus("chg2", 1, 21, 20, 21, 1);

    // Reset on a sample cycle, then restart at k=2
    apply_stimulus("pre_0", 2, 4, 4, 4, 0);
    apply_stimulus("pre_1", 2, 8, 8, 8, 0);
    @(negedge clk);
    reset = 1'b1;
    drive(2, 1'b1, 100);
    @(posedge clk);
    #1;
    check_output("mrst.vld_f", int'(bus_f.out_valid), 0);
    check_output("mrst.vld_r", int'(bus_r.out_valid), 0);
    check_output("mrst.q_f", int'(bus_f.q), 0);
    check_output("mrst.q_r", int'(bus_r.q), 0);
    check_output("mrst.set_f", int'(bus_f.settled), 0);
    @(negedge clk);
    reset = 1'b0;
    drive(2, 1'b0, 0);
    apply_stimulus("rs_0", 2, 1, 1, 1, 0);
    apply_stimulus("rs_1", 2, 2, 2, 2, 0);
    apply_stimulus("rs_2", 2, 3, 3, 3, 0);
    apply_stimulus("rs_3", 2, 5, 2, 3, 1);
    idle_cycle("end_idle", 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
